// File: rtl/led_blink_driver_pkg.sv
// Shared definitions for the LED blink driver.
//   state_t      : FSM state encoding (IDLE / ON / OFF), 2 bits.
//   phase_width  : width of the tick counter that times the ON and OFF phases,
//                  wide enough to hold max(on_ticks, off_ticks).
package led_blink_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    function automatic int phase_width(input int on_ticks, input int off_ticks);
        int m;
        m = (on_ticks > off_ticks) ? on_ticks : off_ticks;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/led_blink_driver_tick_prescaler.sv
// Free-running slow time base.
//   i_clk   : system clock, rising edge
//   i_reset : asynchronous, active-low reset (counter returns to 0)
//   o_tick  : one-cycle pulse every 2^PRESCALE_W cycles, first one in cycle
//             2^PRESCALE_W-1 after reset release
module tick_prescaler #(
    parameter int PRESCALE_W = 17
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    logic [PRESCALE_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Tick on the all-ones count so the counter wrap and the tick coincide.
    assign o_tick = &r_count;

endmodule

// File: rtl/led_blink_driver.sv
// Turns single-cycle event pulses into human-visible LED blinks.
// Each accepted event yields one blink: ON_TICKS ticks lit, then OFF_TICKS
// ticks dark. Events that arrive while a blink is running are counted in a
// saturating pending counter and played back-to-back.
//   i_clk      : system clock, rising edge
//   i_reset    : asynchronous, active-low reset
//   i_event    : request pulse; every high cycle is one event
//   i_clear    : flush pending count and overflow flag (wins over i_event)
//   o_led      : registered LED drive (polarity set by LED_ACTIVE_LOW)
//   o_busy     : blink in progress or events pending
//   o_pending  : number of events waiting for a blink
//   o_overflow : sticky; an event was dropped because the counter was full
//
// Request semantics: there is no ready signal. An i_event cycle is accepted
// unless i_clear is high in the same cycle, or the counter is full and no
// blink is being started in that cycle (then it is dropped and o_overflow
// sets). A blink start consumes one pending event on a tick edge.
module led_blink_driver
    import led_blink_driver_pkg::*;
#(
    parameter int PRESCALE_W     = 17,
    parameter int ON_TICKS       = 8,
    parameter int OFF_TICKS      = 8,
    parameter int PEND_W         = 4,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_event,
    input  logic              i_clear,
    output logic              o_led,
    output logic              o_busy,
    output logic [PEND_W-1:0] o_pending,
    output logic              o_overflow
);

    localparam int                 PHASE_W  = phase_width(ON_TICKS, OFF_TICKS);
    localparam logic [PHASE_W-1:0] ON_LAST  = PHASE_W'(ON_TICKS - 1);
    localparam logic [PHASE_W-1:0] OFF_LAST = PHASE_W'(OFF_TICKS - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = '1;
    localparam logic               LED_OFF  = (LED_ACTIVE_LOW != 0);

    logic               w_tick;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_nxt;
    logic               w_consume;
    logic               w_pend_avail;
    logic               w_at_max;
    logic               w_inc;
    logic               w_drop;
    logic [PEND_W-1:0]  r_pending;
    logic               r_overflow;
    logic               r_led;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (w_tick)
    );

    // A same-cycle clear empties the queue, so it also blocks a blink start.
    assign w_pend_avail = (r_pending != '0) && !i_clear;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_consume   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && w_pend_avail) begin
                    w_state_nxt = ST_ON;
                    w_phase_nxt = '0;
                    w_consume   = 1'b1;
                end
            end
            ST_ON: begin
                if (w_tick) begin
                    if (r_phase == ON_LAST) begin
                        w_state_nxt = ST_OFF;
                        w_phase_nxt = '0;
                    end else begin
                        w_phase_nxt = r_phase + 1'b1;
                    end
                end
            end
            ST_OFF: begin
                if (w_tick) begin
                    if (r_phase == OFF_LAST) begin
                        w_phase_nxt = '0;
                        if (w_pend_avail) begin
                            w_state_nxt = ST_ON;
                            w_consume   = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_phase_nxt = r_phase + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    // A full counter still accepts an event when a blink consumes one in the
    // same cycle: the count stays at max and nothing is lost.
    assign w_at_max = (r_pending == PEND_MAX);
    assign w_inc    = i_event && (!w_at_max || w_consume);
    assign w_drop   = i_event && w_at_max && !w_consume;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending <= r_pending + PEND_W'(w_inc) - PEND_W'(w_consume);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Registered from the next state so the LED is lit exactly while in ON.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_led <= LED_OFF;
        end else begin
            r_led <= (w_state_nxt == ST_ON) ? ~LED_OFF : LED_OFF;
        end
    end

    assign o_led      = r_led;
    assign o_busy     = (r_state != ST_IDLE) || (r_pending != '0);
    assign o_pending  = r_pending;
    assign o_overflow = r_overflow;

endmodule
